ddr_axi_responder: RTL and testbench
====================================

Name: ddr_axi_responder

Overview:
- Simulation/bring-up slave for the SoC's combined read/write DDR AXI master port (io_ddrA_*).
- Accepts combined arw requests, sinks write bursts into a byte-addressable local RAM, and returns read bursts from that RAM.
- Sits in the memoryClk domain in place of the DDR controller, so the SoC bench runs without a DDR model.

Parameters:
- MEM_AW, 10, log2 of RAM depth in 128-bit words (default 1024 words = 16 KiB).
- RD_LAT, 2, cycles from arw handshake (read) to first r_valid; legal range 1..15.
- ID_W, 8, width of all id fields.

Ports:
- io_memoryClk  in  1  clock.
- io_asyncResetn  in  1  asynchronous active-low reset.
- io_ddrA_arw_valid  in  1  request valid.
- io_ddrA_arw_ready  out  1  request accept.
- io_ddrA_arw_payload_addr  in  32  byte address.
- io_ddrA_arw_payload_id  in  ID_W  transaction id.
- io_ddrA_arw_payload_len  in  8  beats minus 1.
- io_ddrA_arw_payload_size  in  3  must be 4 (16 B); other values flagged.
- io_ddrA_arw_payload_burst  in  2  00 FIXED, 01 INCR, 10 WRAP.
- io_ddrA_arw_payload_lock  in  2  ignored.
- io_ddrA_arw_payload_write  in  1  1 = write, 0 = read.
- io_ddrA_w_valid  in  1  write beat valid.
- io_ddrA_w_ready  out  1  write beat accept.
- io_ddrA_w_payload_id  in  ID_W  ignored.
- io_ddrA_w_payload_data  in  128  write data.
- io_ddrA_w_payload_strb  in  16  byte enables.
- io_ddrA_w_payload_last  in  1  last beat marker.
- io_ddrA_b_valid  out  1  write response valid.
- io_ddrA_b_ready  in  1  write response accept.
- io_ddrA_b_payload_id  out  ID_W  echoed id.
- io_ddrA_r_valid  out  1  read beat valid.
- io_ddrA_r_ready  in  1  read beat accept.
- io_ddrA_r_payload_data  out  128  read data.
- io_ddrA_r_payload_id  out  ID_W  echoed id.
- io_ddrA_r_payload_resp  out  2  always 00.
- io_ddrA_r_payload_last  out  1  final beat.
- err_flags  out  3  sticky: [0] w_last mismatch, [1] size != 4, [2] illegal WRAP len or burst = 11.

Behaviour:
- Reset (async assert, sync release): FSM = IDLE. All of the following are 0: arw_ready, w_ready, b_valid, r_valid, r_last, r_data, r_id, b_id, err_flags. RAM contents are not reset.
- One outstanding transaction. FSM states: IDLE, WDATA, WRESP, RWAIT, RDATA.
- IDLE:
  - arw_ready = 1.
  - On arw_valid & arw_ready, capture addr, id, len, burst; word pointer = addr[MEM_AW+3:4]. Higher address bits are ignored (aliasing); addr[3:0] is ignored.
  - write = 1 -> WDATA; write = 0 -> RWAIT with latency counter = RD_LAT-1.
- WDATA:
  - w_ready = 1.
  - Each handshake writes the strb-selected bytes to RAM[ptr], then advances ptr and increments the beat counter.
  - After beat len+1 -> WRESP.
  - Termination is by count only. If w_last = 0 on the final counted beat, or w_last = 1 earlier, set err_flags[0].
- WRESP: b_valid = 1, b_id = captured id. Hold until b_ready, then -> IDLE. arw_ready = 0 until the cycle after the b handshake.
- RWAIT: counter decrements each cycle; at 0 -> RDATA. The first r_valid occurs RD_LAT cycles after the arw handshake cycle.
- RDATA:
  - r_valid = 1; r_data = RAM[ptr]; r_id = captured id; r_last = (beat == len).
  - While r_ready = 0, all r_* outputs stay stable.
  - On handshake, advance ptr. Back-to-back beats run at 1 per cycle, so the RAM read is prefetched.
  - On the handshake with r_last -> IDLE.
- Pointer advance rules:
  - FIXED: ptr unchanged.
  - INCR: ptr+1 modulo 2^MEM_AW.
  - WRAP: ptr = (ptr & ~len) | ((ptr+1) & len); len must be 1, 3, 7 or 15.
  - Illegal WRAP len or burst = 11: set err_flags[2] and treat as INCR.
- size != 4: set err_flags[1]; the transfer still proceeds as 16 B beats.
- len = 0: single beat, r_last asserted on the first beat.
- Reset asserted mid-burst: aborts immediately; outputs return to their reset values; no partial response is emitted after release.

Optional Feature:
- Macro: DDR_RESPONDER_STALL_EN.
- Defined:
  - A 16-bit LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1 at reset) advances every cycle.
  - arw_ready and w_ready are forced to 0 in any cycle where LFSR[1:0] == 2'b00.
  - r_valid assertion is deferred by one cycle each time LFSR[3:2] == 2'b00 while in RDATA before the first valid of a beat.
  - Once r_valid is asserted it is never dropped before the handshake.
- Not defined: no LFSR logic; ready/valid behave exactly as in Behaviour.

Test Plan:
- Write addr 0x40, len 0, strb 16'hFFFF, data 0x0123..EF; then read addr 0x40 -> b_id echoes; r_data matches; r_last = 1; first r_valid exactly RD_LAT = 2 cycles after arw handshake.
- INCR write addr 0x100, len 3, data k*0x11 (k = 0..3); INCR read back with r_ready toggling 1,0,1,0 -> 4 beats in order; data stable during stalls; r_last only on beat 3.
- WRAP read addr 0x130, len 3 -> beats come from words 0x13, 0x10, 0x11, 0x12. FIXED write len 1 to 0x200 -> only the second beat's data remains at 0x200.
- Partial strobe 16'h000F writing 0xAABBCCDD over a word pre-filled with all Fs -> readback 0xFF..FFAABBCCDD.
- Write len 1 with w_last high on beat 0 -> still 2 beats accepted, b_valid issued, err_flags = 3'b001. Request with size = 3 -> err_flags[1] set.
- Assert io_asyncResetn low during beat 2 of a len-7 read -> r_valid falls asynchronously; after release arw_ready = 1 and no stray r/b beats appear.

Source files
------------

// File: rtl/ddr_axi_responder.sv
// DDR AXI bring-up slave: one outstanding arw burst into/out of a local 128-bit RAM.
// Define DDR_RESPONDER_STALL_EN to add LFSR-driven ready/valid stalls.
module ddr_axi_responder #(
   parameter int MEM_AW = 10,
   parameter int RD_LAT = 2,
   parameter int ID_W   = 8
) (
   input  logic              io_memoryClk,
   input  logic              io_asyncResetn,
   input  logic              io_ddrA_arw_valid,
   output logic              io_ddrA_arw_ready,
   input  logic [31:0]       io_ddrA_arw_payload_addr,
   input  logic [ID_W-1:0]   io_ddrA_arw_payload_id,
   input  logic [7:0]        io_ddrA_arw_payload_len,
   input  logic [2:0]        io_ddrA_arw_payload_size,
   input  logic [1:0]        io_ddrA_arw_payload_burst,
   input  logic [1:0]        io_ddrA_arw_payload_lock,
   input  logic              io_ddrA_arw_payload_write,
   input  logic              io_ddrA_w_valid,
   output logic              io_ddrA_w_ready,
   input  logic [ID_W-1:0]   io_ddrA_w_payload_id,
   input  logic [127:0]      io_ddrA_w_payload_data,
   input  logic [15:0]       io_ddrA_w_payload_strb,
   input  logic              io_ddrA_w_payload_last,
   output logic              io_ddrA_b_valid,
   input  logic              io_ddrA_b_ready,
   output logic [ID_W-1:0]   io_ddrA_b_payload_id,
   output logic              io_ddrA_r_valid,
   input  logic              io_ddrA_r_ready,
   output logic [127:0]      io_ddrA_r_payload_data,
   output logic [ID_W-1:0]   io_ddrA_r_payload_id,
   output logic [1:0]        io_ddrA_r_payload_resp,
   output logic              io_ddrA_r_payload_last,
   output logic [2:0]        err_flags
);

   typedef enum logic [2:0] {
      S_IDLE, S_WDATA, S_WRESP, S_RWAIT, S_RDATA
   } state_t;

   localparam logic [MEM_AW-1:0] ONE = MEM_AW'(1);

   state_t            r_state;
   logic [MEM_AW-1:0] r_ptr;
   logic [7:0]        r_len;
   logic [7:0]        r_beat;
   logic [1:0]        r_burst;
   logic [ID_W-1:0]   r_id;
   logic [3:0]        r_cnt;
   logic              r_arw_rdy;
   logic              r_w_rdy;
   logic              r_b_vld;
   logic              r_r_vld;
   logic              r_r_last;
   logic [127:0]      r_r_data;
   logic [ID_W-1:0]   r_r_id;
   logic [ID_W-1:0]   r_b_id;
   logic [2:0]        r_err;
   logic [127:0]      r_mem [0:(1<<MEM_AW)-1];

   logic [MEM_AW-1:0] w_aptr;
   logic [MEM_AW-1:0] w_nptr;
   logic [1:0]        w_burst_eff;
   logic              w_len_ok;
   logic              w_bad_burst;
   logic              w_arw_hs;
   logic              w_w_hs;
   logic              w_b_hs;
   logic              w_r_hs;
   logic              w_wfinal;
   logic [7:0]        w_beat_nxt;
   logic              w_hold;
   logic              w_rgo;
   logic              w_unused;

   function automatic logic [MEM_AW-1:0] f_adv(
      input logic [MEM_AW-1:0] p,
      input logic [1:0]        b,
      input logic [7:0]        l
   );
      logic [MEM_AW-1:0] m;
      m = MEM_AW'(l);
      case (b)
         2'b00:   f_adv = p;
         2'b10:   f_adv = (p & ~m) | ((p + ONE) & m);
         default: f_adv = p + ONE;
      endcase
   endfunction

`ifdef DDR_RESPONDER_STALL_EN
   logic [15:0] r_lfsr;
   logic [15:0] w_lfsr_nxt;
   assign w_lfsr_nxt = {r_lfsr[14:0],
                        r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
   always_ff @(posedge io_memoryClk or negedge io_asyncResetn) begin
      if (!io_asyncResetn) r_lfsr <= 16'hACE1;
      else                 r_lfsr <= w_lfsr_nxt;
   end
   assign w_hold = (r_lfsr[1:0] == 2'b00);
   // r_valid rises only in a cycle whose LFSR[3:2] is non-zero
   assign w_rgo  = (w_lfsr_nxt[3:2] != 2'b00);
`else
   assign w_hold = 1'b0;
   assign w_rgo  = 1'b1;
`endif

   assign w_aptr      = io_ddrA_arw_payload_addr[MEM_AW+3:4];
   assign w_len_ok    = (io_ddrA_arw_payload_len == 8'd1) |
                        (io_ddrA_arw_payload_len == 8'd3) |
                        (io_ddrA_arw_payload_len == 8'd7) |
                        (io_ddrA_arw_payload_len == 8'd15);
   assign w_bad_burst = (io_ddrA_arw_payload_burst == 2'b11) |
                        ((io_ddrA_arw_payload_burst == 2'b10) & ~w_len_ok);
   assign w_burst_eff = w_bad_burst ? 2'b01 : io_ddrA_arw_payload_burst;
   assign w_nptr      = f_adv(r_ptr, r_burst, r_len);
   assign w_wfinal    = (r_beat == r_len);
   assign w_beat_nxt  = r_beat + 8'd1;

   assign io_ddrA_arw_ready = r_arw_rdy & ~w_hold;
   assign io_ddrA_w_ready   = r_w_rdy & ~w_hold;
   assign w_arw_hs = io_ddrA_arw_valid & io_ddrA_arw_ready;
   assign w_w_hs   = io_ddrA_w_valid & io_ddrA_w_ready;
   assign w_b_hs   = r_b_vld & io_ddrA_b_ready;
   assign w_r_hs   = r_r_vld & io_ddrA_r_ready;

   assign io_ddrA_b_valid        = r_b_vld;
   assign io_ddrA_b_payload_id   = r_b_id;
   assign io_ddrA_r_valid        = r_r_vld;
   assign io_ddrA_r_payload_data = r_r_data;
   assign io_ddrA_r_payload_id   = r_r_id;
   assign io_ddrA_r_payload_resp = 2'b00;
   assign io_ddrA_r_payload_last = r_r_last;
   assign err_flags              = r_err;

   assign w_unused = ^{io_ddrA_arw_payload_lock, io_ddrA_w_payload_id,
                       io_ddrA_arw_payload_addr[31:MEM_AW+4],
                       io_ddrA_arw_payload_addr[3:0]};

   always_ff @(posedge io_memoryClk) begin
      if (w_w_hs) begin
         for (int i = 0; i < 16; i++) begin
            if (io_ddrA_w_payload_strb[i])
               r_mem[r_ptr][8*i +: 8] <= io_ddrA_w_payload_data[8*i +: 8];
         end
      end
   end

   always_ff @(posedge io_memoryClk or negedge io_asyncResetn) begin
      if (!io_asyncResetn) begin
         r_state   <= S_IDLE;
         r_ptr     <= '0;
         r_len     <= '0;
         r_beat    <= '0;
         r_burst   <= '0;
         r_id      <= '0;
         r_cnt     <= '0;
         r_arw_rdy <= 1'b0;
         r_w_rdy   <= 1'b0;
         r_b_vld   <= 1'b0;
         r_r_vld   <= 1'b0;
         r_r_last  <= 1'b0;
         r_r_data  <= '0;
         r_r_id    <= '0;
         r_b_id    <= '0;
         r_err     <= '0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               r_arw_rdy <= 1'b1;
               if (w_arw_hs) begin
                  r_arw_rdy <= 1'b0;
                  r_ptr     <= w_aptr;
                  r_id      <= io_ddrA_arw_payload_id;
                  r_len     <= io_ddrA_arw_payload_len;
                  r_burst   <= w_burst_eff;
                  r_beat    <= '0;
                  if (io_ddrA_arw_payload_size != 3'd4) r_err[1] <= 1'b1;
                  if (w_bad_burst)                      r_err[2] <= 1'b1;
                  if (io_ddrA_arw_payload_write) begin
                     r_state <= S_WDATA;
                     r_w_rdy <= 1'b1;
                  end else if (RD_LAT == 1) begin
                     r_state  <= S_RDATA;
                     r_r_vld  <= w_rgo;
                     r_r_data <= r_mem[w_aptr];
                     r_r_id   <= io_ddrA_arw_payload_id;
                     r_r_last <= (io_ddrA_arw_payload_len == 8'd0);
                  end else begin
                     r_state <= S_RWAIT;
                     r_cnt   <= 4'(RD_LAT - 1);
                  end
               end
            end
            S_WDATA: begin
               if (w_w_hs) begin
                  r_ptr  <= w_nptr;
                  r_beat <= w_beat_nxt;
                  if (io_ddrA_w_payload_last != w_wfinal) r_err[0] <= 1'b1;
                  if (w_wfinal) begin
                     r_w_rdy <= 1'b0;
                     r_b_vld <= 1'b1;
                     r_b_id  <= r_id;
                     r_state <= S_WRESP;
                  end
               end
            end
            S_WRESP: begin
               if (w_b_hs) begin
                  r_b_vld   <= 1'b0;
                  r_arw_rdy <= 1'b1;
                  r_state   <= S_IDLE;
               end
            end
            S_RWAIT: begin
               r_cnt <= r_cnt - 4'd1;
               if (r_cnt == 4'd1) begin
                  r_state  <= S_RDATA;
                  r_r_vld  <= w_rgo;
                  r_r_data <= r_mem[r_ptr];
                  r_r_id   <= r_id;
                  r_r_last <= (r_len == 8'd0);
               end
            end
            S_RDATA: begin
               if (!r_r_vld) begin
                  r_r_vld <= w_rgo;
               end else if (w_r_hs) begin
                  if (r_r_last) begin
                     r_r_vld   <= 1'b0;
                     r_r_last  <= 1'b0;
                     r_arw_rdy <= 1'b1;
                     r_state   <= S_IDLE;
                  end else begin
                     // prefetch the next beat so bursts stream at one per cycle
                     r_ptr    <= w_nptr;
                     r_r_data <= r_mem[w_nptr];
                     r_beat   <= w_beat_nxt;
                     r_r_last <= (w_beat_nxt == r_len);
                     r_r_vld  <= w_rgo;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ddr_axi_responder.sv
// Bench for ddr_axi_responder: directed and random bursts checked against
// a word-array memory model with per-byte valid masks.
module tb_ddr_axi_responder;

   localparam int AW  = 10;
   localparam int RDL = 2;
   localparam int IW  = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          arw_valid, arw_ready, arw_write;
   logic [31:0]   arw_addr;
   logic [IW-1:0] arw_id;
   logic [7:0]    arw_len;
   logic [2:0]    arw_size;
   logic [1:0]    arw_burst, arw_lock;
   logic          w_valid, w_ready, w_last;
   logic [IW-1:0] w_id;
   logic [127:0]  w_data;
   logic [15:0]   w_strb;
   logic          b_valid, b_ready;
   logic [IW-1:0] b_id;
   logic          r_valid, r_ready, r_last;
   logic [127:0]  r_data;
   logic [IW-1:0] r_id;
   logic [1:0]    r_resp;
   logic [2:0]    err;

   always #5 clk = ~clk;

   ddr_axi_responder #(.MEM_AW(AW), .RD_LAT(RDL), .ID_W(IW)) dut (
      .io_memoryClk(clk),
      .io_asyncResetn(rst_n),
      .io_ddrA_arw_valid(arw_valid),
      .io_ddrA_arw_ready(arw_ready),
      .io_ddrA_arw_payload_addr(arw_addr),
      .io_ddrA_arw_payload_id(arw_id),
      .io_ddrA_arw_payload_len(arw_len),
      .io_ddrA_arw_payload_size(arw_size),
      .io_ddrA_arw_payload_burst(arw_burst),
      .io_ddrA_arw_payload_lock(arw_lock),
      .io_ddrA_arw_payload_write(arw_write),
      .io_ddrA_w_valid(w_valid),
      .io_ddrA_w_ready(w_ready),
      .io_ddrA_w_payload_id(w_id),
      .io_ddrA_w_payload_data(w_data),
      .io_ddrA_w_payload_strb(w_strb),
      .io_ddrA_w_payload_last(w_last),
      .io_ddrA_b_valid(b_valid),
      .io_ddrA_b_ready(b_ready),
      .io_ddrA_b_payload_id(b_id),
      .io_ddrA_r_valid(r_valid),
      .io_ddrA_r_ready(r_ready),
      .io_ddrA_r_payload_data(r_data),
      .io_ddrA_r_payload_id(r_id),
      .io_ddrA_r_payload_resp(r_resp),
      .io_ddrA_r_payload_last(r_last),
      .err_flags(err)
   );

   int npass = 0;
   int ntot  = 0;
   int cyc   = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // reference memory: word contents plus which bytes have ever been written
   logic [127:0] m_mem [1024];
   logic [15:0]  m_val [1024];
   logic [127:0] q_d[$];
   logic [127:0] q_m[$];
   logic [7:0]   q_id[$];
   bit           q_last[$];
   logic [7:0]   q_b[$];
   logic [127:0] got[$];
   int           hs_cyc;
   bit           first_pend = 1'b0;
   logic [127:0] wd [16];
   logic [15:0]  ws [16];

   task automatic check(input bit ok, input string nm,
                        input logic [127:0] act, input logic [127:0] exp);
      ntot++;
      if (ok) npass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
   endtask

   function automatic int widx(input logic [31:0] a, input logic [1:0] b,
                               input int len, input int k);
      int s, n, base;
      s = int'((a >> 4) & 32'h3FF);
      if (b == 2'b00) return s;
      if (b == 2'b10 && (len == 1 || len == 3 || len == 7 || len == 15)) begin
         n    = len + 1;
         base = s - (s % n);
         return base + ((s - base + k) % n);
      end
      return (s + k) % 1024;
   endfunction

   function automatic logic [127:0] bmask(input logic [15:0] v);
      logic [127:0] m;
      for (int i = 0; i < 16; i++) m[8*i +: 8] = {8{v[i]}};
      return m;
   endfunction

   always @(negedge clk) begin
      if (rst_n) begin
         if (r_valid) begin
            check(q_d.size() != 0, "r_expected", 128'(r_valid), 128'(0));
            if (q_d.size() != 0) begin
               check(((r_data ^ q_d[0]) & q_m[0]) == 128'd0, "r_data",
                     r_data, q_d[0]);
               check(r_id == q_id[0], "r_id", 128'(r_id), 128'(q_id[0]));
               check(r_last == q_last[0], "r_last", 128'(r_last),
                     128'(q_last[0]));
               check(r_resp == 2'b00, "r_resp", 128'(r_resp), 128'(0));
               if (first_pend) begin
                  check(cyc - hs_cyc == RDL, "r_latency",
                        128'(cyc - hs_cyc), 128'(RDL));
                  first_pend = 1'b0;
               end
               if (r_ready) begin
                  got.push_back(r_data);
                  void'(q_d.pop_front());
                  void'(q_m.pop_front());
                  void'(q_id.pop_front());
                  void'(q_last.pop_front());
               end
            end
         end
         if (b_valid) begin
            check(q_b.size() != 0, "b_expected", 128'(b_valid), 128'(0));
            if (q_b.size() != 0) begin
               check(b_id == q_b[0], "b_id", 128'(b_id), 128'(q_b[0]));
               if (b_ready) void'(q_b.pop_front());
            end
         end
      end
   end

   task automatic arw(input logic [31:0] a, input logic [7:0] id,
                      input logic [7:0] len, input logic [1:0] b,
                      input logic [2:0] sz, input bit wr);
      bit ok;
      @(posedge clk); #1;
      arw_addr  = a;
      arw_id    = id;
      arw_len   = len;
      arw_burst = b;
      arw_size  = sz;
      arw_write = wr;
      arw_lock  = 2'($urandom);
      arw_valid = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (arw_ready) begin ok = 1'b1; break; end
      end
      check(ok, "arw_handshake", 128'(ok), 128'(1));
      if (ok && !wr) begin hs_cyc = cyc; first_pend = 1'b1; end
      @(posedge clk); #1;
      arw_valid = 1'b0;
   endtask

   task automatic wr(input logic [31:0] a, input logic [7:0] id,
                     input logic [7:0] len, input logic [1:0] b,
                     input logic [2:0] sz, input bit badlast);
      int idx;
      bit ok;
      for (int k = 0; k <= int'(len); k++) begin
         idx = widx(a, b, int'(len), k);
         for (int y = 0; y < 16; y++) begin
            if (ws[k][y]) begin
               m_mem[idx][8*y +: 8] = wd[k][8*y +: 8];
               m_val[idx][y] = 1'b1;
            end
         end
      end
      q_b.push_back(id);
      arw(a, id, len, b, sz, 1'b1);
      for (int k = 0; k <= int'(len); k++) begin
         if ($urandom % 4 == 0) begin @(posedge clk); #1; end
         w_valid = 1'b1;
         w_data  = wd[k];
         w_strb  = ws[k];
         w_id    = 8'($urandom);
         w_last  = badlast ? (k == 0) : (k == int'(len));
         ok = 1'b0;
         for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (w_ready) begin ok = 1'b1; break; end
         end
         check(ok, "w_handshake", 128'(ok), 128'(1));
         @(posedge clk); #1;
         w_valid = 1'b0;
      end
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(posedge clk); #1;
         if (q_b.size() == 0) begin ok = 1'b1; break; end
         b_ready = 1'($urandom);
      end
      b_ready = 1'b0;
      check(ok, "b_done", 128'(q_b.size()), 128'(0));
   endtask

   task automatic expect_rd(input logic [31:0] a, input logic [7:0] id,
                            input logic [7:0] len, input logic [1:0] b);
      int idx;
      for (int k = 0; k <= int'(len); k++) begin
         idx = widx(a, b, int'(len), k);
         q_d.push_back(m_mem[idx]);
         q_m.push_back(bmask(m_val[idx]));
         q_id.push_back(id);
         q_last.push_back(k == int'(len));
      end
   endtask

   task automatic rd(input logic [31:0] a, input logic [7:0] id,
                     input logic [7:0] len, input logic [1:0] b,
                     input int mode);
      bit ok;
      expect_rd(a, id, len, b);
      arw(a, id, len, b, 3'd4, 1'b0);
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(posedge clk); #1;
         if (q_d.size() == 0) begin ok = 1'b1; break; end
         r_ready = (mode == 0) ? 1'b1 : (mode == 1) ? (i % 2 == 0)
                                                     : 1'($urandom);
      end
      r_ready = 1'b0;
      check(ok, "r_done", 128'(q_d.size()), 128'(0));
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int gb, stray, len, t_b;
      logic [31:0]  a;
      logic [127:0] wexp [4];
      arw_valid = 0; arw_addr = 0; arw_id = 0; arw_len = 0; arw_size = 0;
      arw_burst = 0; arw_lock = 0; arw_write = 0;
      w_valid = 0; w_id = 0; w_data = 0; w_strb = 0; w_last = 0;
      b_ready = 0; r_ready = 0;
      for (int i = 0; i < 1024; i++) begin
         m_mem[i] = '0;
         m_val[i] = '0;
      end

      repeat (3) @(posedge clk);
      #1;
      check(arw_ready == 0, "rst_arw_ready", 128'(arw_ready), 128'(0));
      check(w_ready == 0, "rst_w_ready", 128'(w_ready), 128'(0));
      check(b_valid == 0, "rst_b_valid", 128'(b_valid), 128'(0));
      check(r_valid == 0, "rst_r_valid", 128'(r_valid), 128'(0));
      check(r_last == 0, "rst_r_last", 128'(r_last), 128'(0));
      check(r_data == 0, "rst_r_data", r_data, 128'(0));
      check(r_id == 0, "rst_r_id", 128'(r_id), 128'(0));
      check(b_id == 0, "rst_b_id", 128'(b_id), 128'(0));
      check(err == 0, "rst_err", 128'(err), 128'(0));
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check(arw_ready == 1, "idle_arw_ready", 128'(arw_ready), 128'(1));

      // single beat write then read
      wd[0] = 128'h0123456789ABCDEF0123456789ABCDEF;
      ws[0] = 16'hFFFF;
      wr(32'h40, 8'h5A, 8'd0, 2'b01, 3'd4, 1'b0);
      check(m_mem[4] == 128'h0123456789ABCDEF0123456789ABCDEF, "model_w0",
            m_mem[4], 128'h0123456789ABCDEF0123456789ABCDEF);
      rd(32'h40, 8'hC3, 8'd0, 2'b01, 0);
      check(got[$] == 128'h0123456789ABCDEF0123456789ABCDEF, "tp1_data",
            got[$], 128'h0123456789ABCDEF0123456789ABCDEF);

      // INCR burst, read back with r_ready toggling
      for (int k = 0; k < 4; k++) begin
         wd[k] = 128'(k * 'h11);
         ws[k] = 16'hFFFF;
      end
      wr(32'h100, 8'h11, 8'd3, 2'b01, 3'd4, 1'b0);
      gb = got.size();
      rd(32'h100, 8'h22, 8'd3, 2'b01, 1);
      check(got.size() == gb + 4, "tp2_count", 128'(got.size() - gb), 128'(4));
      if (got.size() == gb + 4)
         for (int k = 0; k < 4; k++)
            check(got[gb+k] == 128'(k * 'h11), "tp2_beat", got[gb+k],
                  128'(k * 'h11));

      // WRAP read starting mid-block
      check(widx(32'h130, 2'b10, 3, 1) == 'h10, "model_wrap",
            128'(widx(32'h130, 2'b10, 3, 1)), 128'('h10));
      wexp[0] = 128'h33; wexp[1] = 128'h0; wexp[2] = 128'h11; wexp[3] = 128'h22;
      gb = got.size();
      rd(32'h130, 8'h33, 8'd3, 2'b10, 2);
      if (got.size() == gb + 4)
         for (int k = 0; k < 4; k++)
            check(got[gb+k] == wexp[k], "tp3_wrap", got[gb+k], wexp[k]);

      // FIXED write: last beat wins
      wd[0] = {4{32'hAAAA5555}};
      wd[1] = {4{32'hBBBB6666}};
      ws[0] = 16'hFFFF;
      ws[1] = 16'hFFFF;
      wr(32'h200, 8'h44, 8'd1, 2'b00, 3'd4, 1'b0);
      rd(32'h200, 8'h45, 8'd0, 2'b01, 0);
      check(got[$] == {4{32'hBBBB6666}}, "tp3_fixed", got[$],
            {4{32'hBBBB6666}});

      // partial strobe over all-ones word
      wd[0] = '1;
      ws[0] = 16'hFFFF;
      wr(32'h300, 8'h50, 8'd0, 2'b01, 3'd4, 1'b0);
      wd[0] = 128'hAABBCCDD;
      ws[0] = 16'h000F;
      wr(32'h300, 8'h51, 8'd0, 2'b01, 3'd4, 1'b0);
      rd(32'h300, 8'h52, 8'd0, 2'b01, 0);
      check(got[$] == 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_AABBCCDD, "tp4_strb",
            got[$], 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_AABBCCDD);
      check(err == 0, "err_clean", 128'(err), 128'(0));

      // random legal traffic, addresses alias through upper bits
      for (int t = 0; t < 40; t++) begin
         a   = $urandom;
         t_b = $urandom_range(0, 2);
         if (t_b == 2) len = (1 << $urandom_range(1, 4)) - 1;
         else          len = $urandom_range(0, 15);
         for (int k = 0; k < 16; k++) begin
            wd[k] = {$urandom, $urandom, $urandom, $urandom};
            ws[k] = ($urandom % 2 == 0) ? 16'hFFFF : 16'($urandom);
         end
         wr(a, 8'($urandom), 8'(len), 2'(t_b), 3'd4, 1'b0);
         if ($urandom % 3 == 0)
            rd($urandom, 8'($urandom), 8'($urandom_range(0, 15)), 2'b01, 2);
         else
            rd(a, 8'($urandom), 8'(len), 2'(t_b), 2);
      end
      check(err == 0, "err_after_random", 128'(err), 128'(0));

      // error flags
      wd[0] = 128'h1111; wd[1] = 128'h2222;
      ws[0] = 16'hFFFF;  ws[1] = 16'hFFFF;
      wr(32'h400, 8'h66, 8'd1, 2'b01, 3'd4, 1'b1);
      check(err == 3'b001, "err_wlast", 128'(err), 128'(3'b001));
      rd(32'h400, 8'h67, 8'd1, 2'b01, 0);
      wr(32'h500, 8'h77, 8'd0, 2'b01, 3'd3, 1'b0);
      check(err == 3'b011, "err_size", 128'(err), 128'(3'b011));
      wr(32'h600, 8'h78, 8'd1, 2'b11, 3'd4, 1'b0);
      check(err == 3'b111, "err_burst", 128'(err), 128'(3'b111));
      rd(32'h600, 8'h79, 8'd1, 2'b01, 0);

      // reset in the middle of a read burst
      gb = got.size();
      expect_rd(32'h100, 8'h88, 8'd7, 2'b01);
      arw(32'h100, 8'h88, 8'd7, 2'b01, 3'd4, 1'b0);
      r_ready = 1'b1;
      stray = 0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk); #1;
         if (got.size() >= gb + 2) begin stray = 1; break; end
      end
      check(stray == 1, "rst_reach_beat2", 128'(got.size() - gb), 128'(2));
      #2;
      rst_n = 1'b0;
      #1;
      check(r_valid == 0, "rst_async_r_valid", 128'(r_valid), 128'(0));
      check(r_last == 0, "rst_async_r_last", 128'(r_last), 128'(0));
      check(r_data == 0, "rst_async_r_data", r_data, 128'(0));
      q_d.delete(); q_m.delete(); q_id.delete(); q_last.delete(); q_b.delete();
      first_pend = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      stray = 0;
      repeat (12) begin
         @(negedge clk);
         if (r_valid || b_valid) stray++;
      end
      check(stray == 0, "no_stray_after_rst", 128'(stray), 128'(0));
      check(arw_ready == 1, "arw_ready_after_rst", 128'(arw_ready), 128'(1));
      check(err == 0, "err_after_rst", 128'(err), 128'(0));
      r_ready = 1'b0;

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule
